seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
Parametrised serial-pattern detector, successor to the fixed 4-bit "0011" Mealy detector. The match pattern and its length are run-time loadable; overlap vs non-overlap is selectable; a saturating match counter is included. Everything runs from the single board clock clock_in. An internal tick strobe replaces the divided clock, so there is no generated clock domain.

Parameters:
PAT_LEN, 4, pattern length in bits (2..16).
CLK_DIV, 50000000, clock_in cycles per sample tick (>=1).
CNT_W, 8, width of the match counter.
RST_PAT, 4'b0011 (PAT_LEN bits), pattern register value after reset.

Ports:
clock_in  input  1  system clock (100 MHz board clock).
Resetn  input  1  asynchronous, active-low reset.
w  input  1  serial data bit, sampled only on sample ticks.
pattern  input  PAT_LEN  new pattern. MSB is the first bit received, LSB the last.
load_pat  input  1  on any clock_in edge, latches pattern into the pattern register.
overlap_en  input  1  1 = overlapping matches allowed; 0 = history cleared after each match.
tick  output  1  one-cycle sample strobe.
z  output  1  one-cycle match pulse.
match_count  output  CNT_W  number of matches, saturating.

Behaviour:
- Reset (Resetn=0, async):
  - div counter=0, tick=0, z=0, match_count=0.
  - history=0, fill=0, pattern register=RST_PAT.
- Tick generator:
  - div counter runs 0..CLK_DIV-1 then wraps.
  - tick=1 for exactly one clock_in cycle when the counter equals CLK_DIV-1.
  - With CLK_DIV=1, tick is constantly 1.
- Detector state:
  - history is a PAT_LEN-1 bit shift register of previous samples, oldest at MSB.
  - fill is a saturating count of valid samples, 0..PAT_LEN-1.
- On a clock_in edge with tick=1:
  - cand = {history, w}.
  - hit = (fill == PAT_LEN-1) && (cand == pattern register).
  - On hit:
    - z<=1 on the next edge (registered; visible the cycle after tick, high for one clock_in cycle).
    - match_count increments; it holds at 2^CNT_W-1 once there.
    - If overlap_en=1: history shifts in w, fill is unchanged.
    - If overlap_en=0: history<=0, fill<=0.
  - No hit: history shifts in w; fill increments unless already saturated; z<=0.
- On all non-tick edges, z<=0 and detector state holds.
- load_pat=1:
  - Pattern register updated; history and fill cleared.
  - Takes priority over a simultaneous tick: that sample is discarded and z stays 0.
  - match_count is unaffected.
- overlap_en is sampled on each tick. Changing it between ticks is legal.
- Reset mid-sequence: all partial progress is lost immediately. The first match is possible only after PAT_LEN fresh ticks.
- No match can occur with fewer than PAT_LEN samples since reset, load, or a non-overlap match.

Optional Feature:
Macro SEQ_DET_DIRECT_CLK_EN.
- Defined: the divider is removed, CLK_DIV is ignored, and tick is tied to 1, so every clock_in edge samples w. Intended for simulation and fast-clock use.
- Undefined: the divider operates as specified above.
- All other behaviour is identical in both builds.

Test Plan:
1. Bench uses CLK_DIV=4, PAT_LEN=4, default pattern. Reset, then drive w=0,0,1,1 on 4 ticks -> z pulses once, 1 clock_in cycle after the 4th tick; match_count=1; tick period is 4 cycles.
2. Load pattern 4'b1010 with overlap_en=1, send 1,0,1,0,1,0 -> 2 z pulses (after the 4th and 6th samples); match_count=2.
3. Same pattern and stream with overlap_en=0 -> 1 z pulse (after the 4th sample only); match_count=1.
4. Assert Resetn=0 after the samples 0,0,1, release, then send 1 -> no z. Then send 0,0,1,1 -> z, match_count=1.
5. Pulse load_pat coincident with a tick during the partial sequence 0,0,1 -> that sample is dropped, no z; the next full 4-sample match is detected.
6. CNT_W=2 with 5 consecutive overlapping matches of 4'b1111 (w held at 1 for 8 ticks) -> match_count saturates at 3; z still pulses for every match.

Source files
------------

// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time loadable serial pattern detector.
// Samples w on an internal tick strobe derived from clock_in, flags a match
// with a registered one-cycle pulse on z and keeps a saturating match count.
// Build option: define SEQ_DET_DIRECT_CLK_EN to drop the divider and sample
// w on every clock_in edge (CLK_DIV is then ignored).
module seq_detector_param #(
   parameter int unsigned           PAT_LEN = 4,
   parameter int unsigned           CLK_DIV = 50000000,
   parameter int unsigned           CNT_W   = 8,
   parameter logic [PAT_LEN-1:0]    RST_PAT = PAT_LEN'(4'b0011)
) (
   input  logic                clock_in,
   input  logic                Resetn,
   input  logic                w,
   input  logic [PAT_LEN-1:0]  pattern,
   input  logic                load_pat,
   input  logic                overlap_en,
   output logic                tick,
   output logic                z,
   output logic [CNT_W-1:0]    match_count
);

   localparam int unsigned HW = PAT_LEN - 1;
   localparam int unsigned FW = $clog2(PAT_LEN);

   logic               w_tick;
   logic [PAT_LEN-1:0] w_cand;
   logic [HW-1:0]      w_shift;
   logic               w_full;
   logic               w_hit;

   logic [HW-1:0]      r_hist;
   logic [FW-1:0]      r_fill;
   logic [PAT_LEN-1:0] r_pat;
   logic               r_z;
   logic [CNT_W-1:0]   r_cnt;

`ifdef SEQ_DET_DIRECT_CLK_EN
   assign w_tick = 1'b1;
`else
   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] r_div;

   // Divider: counts 0..CLK_DIV-1 and wraps; tick decodes the last count.
   always_ff @(posedge clock_in or negedge Resetn) begin
      if (!Resetn)
         r_div <= '0;
      else if (r_div == DW'(CLK_DIV - 1))
         r_div <= '0;
      else
         r_div <= r_div + DW'(1);
   end

   assign w_tick = (r_div == DW'(CLK_DIV - 1));
`endif

   // The shifted history is the low bits of the candidate word, which also
   // covers PAT_LEN=2 where the history is a single bit.
   assign w_cand  = {r_hist, w};
   assign w_shift = w_cand[HW-1:0];
   assign w_full  = (r_fill == FW'(PAT_LEN - 1));
   assign w_hit   = w_tick && !load_pat && w_full && (w_cand == r_pat);

   // Pattern register, sample history, fill level and match pulse.
   always_ff @(posedge clock_in or negedge Resetn) begin
      if (!Resetn) begin
         r_hist <= '0;
         r_fill <= '0;
         r_pat  <= RST_PAT;
         r_z    <= 1'b0;
      end else begin
         r_z <= 1'b0;
         if (load_pat) begin
            r_pat  <= pattern;
            r_hist <= '0;
            r_fill <= '0;
         end else if (w_tick) begin
            if (w_hit) begin
               r_z <= 1'b1;
               if (overlap_en) begin
                  r_hist <= w_shift;
               end else begin
                  r_hist <= '0;
                  r_fill <= '0;
               end
            end else begin
               r_hist <= w_shift;
               if (!w_full)
                  r_fill <= r_fill + FW'(1);
            end
         end
      end
   end

   // Saturating match counter; untouched by pattern loads.
   always_ff @(posedge clock_in or negedge Resetn) begin
      if (!Resetn)
         r_cnt <= '0;
      else if (w_hit && (r_cnt != '1))
         r_cnt <= r_cnt + CNT_W'(1);
   end

   assign tick        = w_tick;
   assign z           = r_z;
   assign match_count = r_cnt;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param with CLK_DIV=4, PAT_LEN=4. Expected z values
// are pushed when each sample is driven and popped after the tick edge.
// A second instance with CNT_W=2 shares all inputs to exercise saturation.
module tb_seq_detector_param;

   logic       clock_in = 1'b0;
   logic       Resetn   = 1'b0;
   logic       w        = 1'b0;
   logic [3:0] pattern  = 4'b0000;
   logic       load_pat = 1'b0;
   logic       overlap_en = 1'b1;
   logic       tick, z, tick2, z2;
   logic [7:0] match_count;
   logic [1:0] match_count2;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned z_pulses = 0;

   logic       q[$];
   logic [2:0] m_hist;
   int unsigned m_fill;
   logic [3:0] m_pat;

   seq_detector_param #(.PAT_LEN(4), .CLK_DIV(4), .CNT_W(8), .RST_PAT(4'b0011)) dut (
      .clock_in(clock_in), .Resetn(Resetn), .w(w), .pattern(pattern),
      .load_pat(load_pat), .overlap_en(overlap_en), .tick(tick), .z(z),
      .match_count(match_count));

   seq_detector_param #(.PAT_LEN(4), .CLK_DIV(4), .CNT_W(2), .RST_PAT(4'b0011)) dut2 (
      .clock_in(clock_in), .Resetn(Resetn), .w(w), .pattern(pattern),
      .load_pat(load_pat), .overlap_en(overlap_en), .tick(tick2), .z(z2),
      .match_count(match_count2));

   always #5 clock_in = ~clock_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Drive one sample on the next tick edge (or a load coincident with it).
   task automatic send(input logic b, input logic ld);
      logic e;
      int unsigned n = 0;
      while (!tick && n < 20) begin
         @(negedge clock_in);
         n++;
      end
      check("tick_wait", tick, 1);
      w = b;
      load_pat = ld;
      e = 1'b0;
      if (ld) begin
         m_hist = '0; m_fill = 0; m_pat = pattern;
      end else begin
         e = (m_fill == 3) && ({m_hist, b} == m_pat);
         if (e && !overlap_en) begin
            m_hist = '0; m_fill = 0;
         end else begin
            m_hist = {m_hist[1:0], b};
            if (!e && m_fill < 3) m_fill++;
         end
      end
      q.push_back(e);
      @(negedge clock_in);
   endtask

   // Hold load_pat high while idle so spare ticks cannot change state.
   task automatic idle(input logic [3:0] p);
      pattern = p;
      load_pat = 1'b1;
      m_hist = '0; m_fill = 0; m_pat = p;
   endtask

   task automatic do_reset();
      load_pat = 1'b0;
      w = 1'b0;
      Resetn = 1'b0;
      @(negedge clock_in);
      @(negedge clock_in);
      check("rst_tick", tick, 0);
      check("rst_z", z, 0);
      check("rst_cnt", match_count, 0);
      Resetn = 1'b1;
      z_pulses = 0;
      m_hist = '0; m_fill = 0; m_pat = 4'b0011;
   endtask

   task automatic finish_test(input string tag, input int unsigned cnt, input int unsigned pulses);
      idle(pattern);
      repeat (2) @(negedge clock_in);
      check({tag, "_cnt"}, match_count, cnt);
      check({tag, "_pulses"}, z_pulses, pulses);
      check({tag, "_q"}, q.size(), 0);
   endtask

   // Scoreboard side: compare z right after every tick edge.
   initial begin
      logic t, e, pw;
      pw = 1'b0;
      forever begin
         @(posedge clock_in);
         t = tick && Resetn;
         #1;
         if (t) begin
            e = (q.size() > 0) ? q.pop_front() : 1'b0;
            check("z", z, e);
            check("z_dut2", z2, e);
            if (z) z_pulses++;
            pw = z;
         end else if (pw) begin
            check("z_width", z, 0);
            pw = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end

   initial begin
      int unsigned n;
      @(negedge clock_in);

      // Tick period and width
      do_reset();
      n = 0;
      while (!tick && n < 20) begin @(negedge clock_in); n++; end
      @(negedge clock_in);
      check("tick_width", tick, 0);
      n = 1;
      while (!tick && n < 20) begin @(negedge clock_in); n++; end
      check("tick_period", n, 4);

      // 1: default pattern 0011
      do_reset();
      pattern = 4'b0000;
      overlap_en = 1'b1;
      send(0, 0); send(0, 0); send(1, 0); send(1, 0);
      finish_test("t1", 1, 1);

      // 2: 1010 overlapping
      do_reset();
      idle(4'b1010);
      overlap_en = 1'b1;
      send(1, 0); send(0, 0); send(1, 0); send(0, 0); send(1, 0); send(0, 0);
      finish_test("t2", 2, 2);

      // 3: 1010 non-overlapping
      do_reset();
      idle(4'b1010);
      overlap_en = 1'b0;
      send(1, 0); send(0, 0); send(1, 0); send(0, 0); send(1, 0); send(0, 0);
      finish_test("t3", 1, 1);

      // 4: reset mid-sequence
      do_reset();
      overlap_en = 1'b1;
      send(0, 0); send(0, 0); send(1, 0);
      do_reset();
      send(1, 0);
      check("t4_nz_cnt", match_count, 0);
      send(0, 0); send(0, 0); send(1, 0); send(1, 0);
      finish_test("t4", 1, 1);

      // 5: load coincident with a tick drops that sample
      do_reset();
      send(0, 0); send(0, 0); send(1, 0);
      pattern = 4'b0011;
      send(1, 1);
      check("t5_nz_cnt", match_count, 0);
      send(0, 0); send(0, 0); send(1, 0); send(1, 0);
      finish_test("t5", 1, 1);

      // 6: saturation of the 2-bit counter
      do_reset();
      idle(4'b1111);
      overlap_en = 1'b1;
      for (int i = 0; i < 8; i++) send(1, 0);
      finish_test("t6", 5, 5);
      check("t6_cnt2_sat", match_count2, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
